// File: rtl/instr_queue_pkg.sv
// Shared types for the instruction queue: instruction type encodings, field
// widths and the packed entry payload stored per queue slot.
package instr_queue_pkg;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned ENTRY_W = TYPE_W + INSTR_W + 4 * ADDR_W;

  typedef enum logic [TYPE_W-1:0] {
    INSTR_TYPE_CACHE = 2'd0,
    INSTR_TYPE_RAM   = 2'd1,
    INSTR_TYPE_ALU   = 2'd2,
    INSTR_TYPE_LOOP  = 2'd3
  } instr_type_e;

  typedef struct packed {
    instr_type_e               instr_type;
    logic [INSTR_W-1:0]        instruction;
    logic [ADDR_W-1:0]         cache_addr;
    logic [ADDR_W-1:0]         main_mem_addr;
    logic [ADDR_W-1:0]         d_cache_addr;
    logic [ADDR_W-1:0]         d_main_mem_addr;
  } queue_entry_t;

endpackage

// File: rtl/instr_queue_fifo_storage.sv
// Entry register array for the instruction queue.
// Ports: clk; write port (we, waddr, wdata); combinational read port
// (raddr -> rdata). Contents are not reset; validity is tracked by the owner.
module instr_queue_fifo_storage
  import instr_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  queue_entry_t         wdata,
  input  logic [LOG_DEPTH-1:0] raddr,
  output queue_entry_t         rdata
);

  queue_entry_t mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // First-word-fall-through read
  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// In-order typed instruction FIFO between control_unit and the execution
// units. Only the head entry may dispatch, via a per-type ready handshake.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   queue_we, queue_instr_type, raw_instruction, cache_addr, main_mem_addr,
//   d_cache_addr, d_main_mem_addr    push side from control_unit
//   queue_full, queue_almost_full, queue_count   occupancy back-pressure
//   head_valid, head_*               oldest entry (fall-through)
//   unit_ready                       per-type execution unit ready
//   head_pop                         dispatch strobe (combinational)
//   overflow_err, illegal_type_err   sticky error flags
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int unsigned DEPTH             = 8,
  parameter int unsigned LOG_DEPTH         = 3,
  parameter int unsigned ALMOST_FULL_LEVEL = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  queue_we,
  input  logic [TYPE_W-1:0]     queue_instr_type,
  input  logic [INSTR_W-1:0]    raw_instruction,
  input  logic [ADDR_W-1:0]     cache_addr,
  input  logic [ADDR_W-1:0]     main_mem_addr,
  input  logic [ADDR_W-1:0]     d_cache_addr,
  input  logic [ADDR_W-1:0]     d_main_mem_addr,
  output logic                  queue_full,
  output logic                  queue_almost_full,
  output logic [LOG_DEPTH:0]    queue_count,
  output logic                  head_valid,
  output logic [TYPE_W-1:0]     head_type,
  output logic [INSTR_W-1:0]    head_instruction,
  output logic [ADDR_W-1:0]     head_cache_addr,
  output logic [ADDR_W-1:0]     head_main_mem_addr,
  output logic [ADDR_W-1:0]     head_d_cache_addr,
  output logic [ADDR_W-1:0]     head_d_main_mem_addr,
  input  logic [3:0]            unit_ready,
  output logic                  head_pop,
  output logic                  overflow_err,
  output logic                  illegal_type_err
);

  localparam int unsigned CNT_W = LOG_DEPTH + 1;

  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [CNT_W-1:0]     count;

  logic                 push_acc;
  logic                 is_loop;
  queue_entry_t         wr_entry;
  queue_entry_t         head_entry;

  // Occupancy flags derive from the registered count only
  assign queue_full        = (count == CNT_W'(DEPTH));
  assign queue_almost_full = (count >= CNT_W'(ALMOST_FULL_LEVEL));
  assign queue_count       = count;
  assign head_valid        = (count != '0);

  // Push qualification: loop instructions are never queued
  assign is_loop  = (queue_instr_type == INSTR_TYPE_LOOP);
  assign push_acc = queue_we & ~queue_full & ~is_loop;

  // Dispatch looks only at the ready bit of the head entry's type
  assign head_pop = head_valid & unit_ready[head_entry.instr_type];

  assign wr_entry = '{
    instr_type:      instr_type_e'(queue_instr_type),
    instruction:     raw_instruction,
    cache_addr:      cache_addr,
    main_mem_addr:   main_mem_addr,
    d_cache_addr:    d_cache_addr,
    d_main_mem_addr: d_main_mem_addr
  };

  instr_queue_fifo_storage #(
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  assign head_type            = head_entry.instr_type;
  assign head_instruction     = head_entry.instruction;
  assign head_cache_addr      = head_entry.cache_addr;
  assign head_main_mem_addr   = head_entry.main_mem_addr;
  assign head_d_cache_addr    = head_entry.d_cache_addr;
  assign head_d_main_mem_addr = head_entry.d_main_mem_addr;

  // Pointers, occupancy and sticky errors
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      overflow_err     <= 1'b0;
      illegal_type_err <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      end
      if (head_pop) begin
        rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      end
      count <= count + CNT_W'(push_acc) - CNT_W'(head_pop);
      // A push while full is dropped even if the head pops this cycle
      if (queue_we && queue_full) begin
        overflow_err <= 1'b1;
      end
      if (queue_we && is_loop) begin
        illegal_type_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;
  import instr_queue_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              queue_we;
  logic [1:0]        queue_instr_type;
  logic [15:0]       raw_instruction;
  logic [17:0]       cache_addr;
  logic [17:0]       main_mem_addr;
  logic [17:0]       d_cache_addr;
  logic [17:0]       d_main_mem_addr;
  logic              queue_full;
  logic              queue_almost_full;
  logic [3:0]        queue_count;
  logic              head_valid;
  logic [1:0]        head_type;
  logic [15:0]       head_instruction;
  logic [17:0]       head_cache_addr;
  logic [17:0]       head_main_mem_addr;
  logic [17:0]       head_d_cache_addr;
  logic [17:0]       head_d_main_mem_addr;
  logic [3:0]        unit_ready;
  logic              head_pop;
  logic              overflow_err;
  logic              illegal_type_err;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [3:0] RDY_RAM = 4'b0010;
  localparam logic [3:0] RDY_ALU = 4'b0100;

  always #5 clk = ~clk;

  instr_queue dut (
    .clk                  (clk),
    .reset                (reset),
    .queue_we             (queue_we),
    .queue_instr_type     (queue_instr_type),
    .raw_instruction      (raw_instruction),
    .cache_addr           (cache_addr),
    .main_mem_addr        (main_mem_addr),
    .d_cache_addr         (d_cache_addr),
    .d_main_mem_addr      (d_main_mem_addr),
    .queue_full           (queue_full),
    .queue_almost_full    (queue_almost_full),
    .queue_count          (queue_count),
    .head_valid           (head_valid),
    .head_type            (head_type),
    .head_instruction     (head_instruction),
    .head_cache_addr      (head_cache_addr),
    .head_main_mem_addr   (head_main_mem_addr),
    .head_d_cache_addr    (head_d_cache_addr),
    .head_d_main_mem_addr (head_d_main_mem_addr),
    .unit_ready           (unit_ready),
    .head_pop             (head_pop),
    .overflow_err         (overflow_err),
    .illegal_type_err     (illegal_type_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Load the push inputs without clocking
  task automatic set_push(input logic [1:0] t, input logic [15:0] ins,
                          input logic [17:0] ca, input logic [17:0] ma);
    queue_we         = 1'b1;
    queue_instr_type = t;
    raw_instruction  = ins;
    cache_addr       = ca;
    main_mem_addr    = ma;
    d_cache_addr     = 18'(ca + 18'd1);
    d_main_mem_addr  = 18'(ma + 18'd2);
  endtask

  task automatic push(input logic [1:0] t, input logic [15:0] ins,
                      input logic [17:0] ca, input logic [17:0] ma);
    set_push(t, ins, ca, ma);
    tick();
    queue_we = 1'b0;
  endtask

  // Expects unit_ready to already admit the head type
  task automatic pop_check(input string tag, input logic [17:0] exp_ca);
    #1;
    chk({tag, "_valid"}, 32'(head_valid), 32'd1);
    chk({tag, "_pop"}, 32'(head_pop), 32'd1);
    chk({tag, "_ca"}, 32'(head_cache_addr), 32'(exp_ca));
    tick();
  endtask

  initial begin
    int k_push;
    int k_pop;

    reset            = 1'b1;
    queue_we         = 1'b0;
    queue_instr_type = 2'd0;
    raw_instruction  = '0;
    cache_addr       = '0;
    main_mem_addr    = '0;
    d_cache_addr     = '0;
    d_main_mem_addr  = '0;
    unit_ready       = 4'b0000;
    tick();
    tick();
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      chk("idle_valid", 32'(head_valid), 32'd0);
      chk("idle_count", 32'(queue_count), 32'd0);
      chk("idle_full", 32'(queue_full), 32'd0);
      chk("idle_afull", 32'(queue_almost_full), 32'd0);
      chk("idle_pop", 32'(head_pop), 32'd0);
      tick();
    end

    // Single RAM push, held until its unit is ready
    push(INSTR_TYPE_RAM, 16'h1234, 18'd0, 18'd3);
    chk("one_valid", 32'(head_valid), 32'd1);
    chk("one_type", 32'(head_type), 32'(INSTR_TYPE_RAM));
    chk("one_ma", 32'(head_main_mem_addr), 32'd3);
    chk("one_ca", 32'(head_cache_addr), 32'd0);
    chk("one_instr", 32'(head_instruction), 32'h1234);
    chk("one_dca", 32'(head_d_cache_addr), 32'd1);
    chk("one_dma", 32'(head_d_main_mem_addr), 32'd5);
    chk("one_pop_low", 32'(head_pop), 32'd0);
    chk("one_count", 32'(queue_count), 32'd1);
    unit_ready = RDY_RAM;
    #1;
    chk("one_pop_high", 32'(head_pop), 32'd1);
    tick();
    unit_ready = 4'b0000;
    chk("one_after_valid", 32'(head_valid), 32'd0);
    chk("one_after_count", 32'(queue_count), 32'd0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < 8; i++) begin
      push(INSTR_TYPE_ALU, 16'(16'h0100 + i), 18'(2 * i), 18'(i));
      chk("fill_count", 32'(queue_count), 32'(i + 1));
      chk("fill_afull", 32'(queue_almost_full), 32'((i + 1) >= 6));
      chk("fill_full", 32'(queue_full), 32'((i + 1) == 8));
    end
    chk("fill_ovf_before", 32'(overflow_err), 32'd0);
    push(INSTR_TYPE_ALU, 16'h0DEA, 18'd99, 18'd99);
    chk("ovf_count", 32'(queue_count), 32'd8);
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    unit_ready = RDY_ALU;
    for (int i = 0; i < 8; i++) begin
      pop_check("drain", 18'(2 * i));
    end
    unit_ready = 4'b0000;
    chk("drain_count", 32'(queue_count), 32'd0);
    chk("drain_valid", 32'(head_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow_err), 32'd1);

    // Wrap-around: bursts of up to 3 pushes then drain, 20 entries total
    do_reset();
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    k_push = 0;
    k_pop  = 0;
    while (k_pop < 20) begin
      unit_ready = 4'b0000;
      for (int j = 0; j < 3 && k_push < 20; j++) begin
        push(2'(k_push % 3), 16'(16'hA000 + k_push), 18'(k_push * 5 + 1), 18'(k_push * 7));
        chk("wrap_full_push", 32'(queue_full), 32'd0);
        k_push++;
      end
      unit_ready = 4'b0111;
      while (k_pop < k_push) begin
        #1;
        chk("wrap_type", 32'(head_type), 32'(k_pop % 3));
        chk("wrap_instr", 32'(head_instruction), 32'(16'hA000 + k_pop));
        chk("wrap_ca", 32'(head_cache_addr), 32'(k_pop * 5 + 1));
        chk("wrap_ma", 32'(head_main_mem_addr), 32'(k_pop * 7));
        chk("wrap_dca", 32'(head_d_cache_addr), 32'(k_pop * 5 + 2));
        chk("wrap_dma", 32'(head_d_main_mem_addr), 32'(k_pop * 7 + 2));
        chk("wrap_pop", 32'(head_pop), 32'd1);
        tick();
        chk("wrap_full_pop", 32'(queue_full), 32'd0);
        k_pop++;
      end
    end
    unit_ready = 4'b0000;
    chk("wrap_count", 32'(queue_count), 32'd0);

    // Simultaneous push and pop at count 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(INSTR_TYPE_ALU, 16'h0, 18'(100 + i), 18'd0);
    end
    set_push(INSTR_TYPE_ALU, 16'h0, 18'd103, 18'd0);
    unit_ready = RDY_ALU;
    #1;
    chk("pp3_pop", 32'(head_pop), 32'd1);
    tick();
    queue_we = 1'b0;
    chk("pp3_count", 32'(queue_count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      pop_check("pp3_drain", 18'(100 + i));
    end
    unit_ready = 4'b0000;
    chk("pp3_empty", 32'(queue_count), 32'd0);

    // Push while full, head popping in the same cycle
    for (int i = 0; i < 8; i++) begin
      push(INSTR_TYPE_ALU, 16'h0, 18'(200 + i), 18'd0);
    end
    chk("pp8_full", 32'(queue_full), 32'd1);
    set_push(INSTR_TYPE_ALU, 16'h0, 18'd299, 18'd0);
    unit_ready = RDY_ALU;
    #1;
    chk("pp8_pop", 32'(head_pop), 32'd1);
    tick();
    queue_we = 1'b0;
    chk("pp8_count", 32'(queue_count), 32'd7);
    chk("pp8_ovf", 32'(overflow_err), 32'd1);
    for (int i = 1; i < 8; i++) begin
      pop_check("pp8_drain", 18'(200 + i));
    end
    unit_ready = 4'b0000;
    chk("pp8_empty", 32'(queue_count), 32'd0);

    // Head blocking and illegal type
    do_reset();
    push(INSTR_TYPE_RAM, 16'h0, 18'd50, 18'd0);
    push(INSTR_TYPE_ALU, 16'h0, 18'd51, 18'd0);
    unit_ready = RDY_ALU;
    #1;
    chk("blk_pop", 32'(head_pop), 32'd0);
    tick();
    tick();
    chk("blk_count", 32'(queue_count), 32'd2);
    chk("blk_type", 32'(head_type), 32'(INSTR_TYPE_RAM));
    chk("blk_ca", 32'(head_cache_addr), 32'd50);
    unit_ready = 4'b0000;
    push(INSTR_TYPE_LOOP, 16'h0, 18'd52, 18'd0);
    chk("loop_count", 32'(queue_count), 32'd2);
    chk("loop_err", 32'(illegal_type_err), 32'd1);
    chk("loop_no_ovf", 32'(overflow_err), 32'd0);
    for (int i = 0; i < 7; i++) begin
      push(INSTR_TYPE_ALU, 16'h0, 18'(60 + i), 18'd0);
    end
    chk("mid_count", 32'(queue_count), 32'd8);
    chk("mid_ovf", 32'(overflow_err), 32'd1);

    // Mid-stream reset
    do_reset();
    chk("mrst_count", 32'(queue_count), 32'd0);
    chk("mrst_valid", 32'(head_valid), 32'd0);
    chk("mrst_full", 32'(queue_full), 32'd0);
    chk("mrst_ovf", 32'(overflow_err), 32'd0);
    chk("mrst_ill", 32'(illegal_type_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
